// File: rtl/incdec_scheduler_pkg.sv
// Shared definitions for the increment/decrement scheduler.
//   state_t  : scheduler FSM encoding (IDLE=0, EXEC=1)
//   MODE_INC : request mode code for increment
//   MODE_DEC : request mode code for decrement
package incdec_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic MODE_INC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/incdec_scheduler_inc_dec.sv
// Ripple increment/decrement unit (purely combinational).
//   a   : operand
//   dec : 0 = y is a+1, 1 = y is a-1 (both modulo 2^N)
//   y   : result
module inc_dec #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic         dec,
  output logic [N-1:0] y
);

  // c[i] is the carry (increment) or borrow (decrement) into bit i.
  logic [N-1:0] c;

  // NOTE: every variable written in always_comb gets a value before any
  // conditional or loop path, so no latch can be inferred.
  always_comb begin
    c = '0;
    y = '0;
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      y[i] = a[i] ^ c[i];
      // Carry ripples through ones on increment, borrow through zeros on
      // decrement; a[i] ^ dec is 1 exactly in the propagating case.
      if (i < N - 1) c[i+1] = c[i] & (a[i] ^ dec);
    end
  end

endmodule

// File: rtl/incdec_scheduler.sv
// Two-requester increment/decrement scheduler with one shared datapath.
// Each requester owns one N-bit counter; a round-robin arbiter grants one
// request at a time, the op executes in a single EXEC cycle, and the result
// is written back together with a one-cycle done pulse and overflow flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of both counters; aborts an op in EXEC
//   req_valid  : per-requester request
//   req_mode   : per-requester mode (MODE_INC / MODE_DEC)
//   req_ready  : per-requester accept, one-hot or zero
//   cnt0, cnt1 : counters owned by requester 0 / 1
//   done       : one-cycle write-back pulse for the served requester
//   ovf        : valid with done; op wrapped (SAT=0) or was clamped (SAT=1)
module incdec_scheduler
  import incdec_scheduler_pkg::*;
#(
  parameter int N   = 4,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [1:0]   req_valid,
  input  logic [1:0]   req_mode,
  output logic [1:0]   req_ready,
  output logic [N-1:0] cnt0,
  output logic [N-1:0] cnt1,
  output logic [1:0]   done,
  output logic         ovf
);

  state_t       state_q, state_d;
  logic         rr_q;      // preferred requester when both are valid
  logic         g_q;       // granted requester of the op in flight
  logic         mode_q;    // mode of the op in flight
  logic [N-1:0] opnd_q;    // counter value captured at accept

  logic         g_sel;
  logic         accept;
  logic         wb;
  logic         ovf_c;
  logic [N-1:0] inc_y;
  logic [N-1:0] result;

  // Contention goes to rr_q; a lone requester always wins.
  assign g_sel  = (&req_valid) ? rr_q : req_valid[1];
  // rst_n gates accept so req_ready stays low for the whole reset window.
  assign accept = rst_n & ~clr & (state_q == IDLE) & (|req_valid);
  assign wb     = (state_q == EXEC) & ~clr;

  always_comb begin
    req_ready = '0;
    state_d   = state_q;
    if (accept) req_ready[g_sel] = 1'b1;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = EXEC;
        EXEC:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  inc_dec #(.N(N)) u_inc_dec (
    .a   (opnd_q),
    .dec (mode_q),
    .y   (inc_y)
  );

  assign ovf_c  = (mode_q == MODE_DEC) ? (opnd_q == '0) : (&opnd_q);
  // Saturating builds keep the operand when the op would wrap.
  assign result = ((SAT != 0) && ovf_c) ? opnd_q : inc_y;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      g_q     <= 1'b0;
      mode_q  <= MODE_INC;
      opnd_q  <= '0;
      cnt0    <= '0;
      cnt1    <= '0;
      done    <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= '0;
      ovf     <= 1'b0;
      if (clr) begin
        cnt0 <= '0;
        cnt1 <= '0;
      end else begin
        if (accept) begin
          g_q    <= g_sel;
          mode_q <= req_mode[g_sel];
          opnd_q <= g_sel ? cnt1 : cnt0;
          rr_q   <= ~g_sel;
        end
        if (wb) begin
          if (g_q) cnt1 <= result;
          else     cnt0 <= result;
          done[g_q] <= 1'b1;
          ovf       <= ovf_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_incdec_scheduler.sv
// Self-checking bench for incdec_scheduler: a wrap-around instance (SAT=0)
// driven from a vector table plus directed sequences, and a saturating
// instance (SAT=1) for clamp behaviour.
module tb_incdec_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr;
  logic [1:0] w_valid, w_mode, w_ready, w_done;
  logic [3:0] w_cnt0, w_cnt1;
  logic       w_ovf;
  logic [1:0] s_valid, s_mode, s_ready, s_done;
  logic [3:0] s_cnt0, s_cnt1;
  logic       s_ovf;

  logic       cur_sel;
  logic [1:0] o_ready, o_done;
  logic [3:0] o_cnt0, o_cnt1;
  logic       o_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  incdec_scheduler #(.N(4), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_valid(w_valid), .req_mode(w_mode), .req_ready(w_ready),
    .cnt0(w_cnt0), .cnt1(w_cnt1), .done(w_done), .ovf(w_ovf)
  );

  incdec_scheduler #(.N(4), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_valid(s_valid), .req_mode(s_mode), .req_ready(s_ready),
    .cnt0(s_cnt0), .cnt1(s_cnt1), .done(s_done), .ovf(s_ovf)
  );

  assign o_ready = cur_sel ? s_ready : w_ready;
  assign o_done  = cur_sel ? s_done  : w_done;
  assign o_cnt0  = cur_sel ? s_cnt0  : w_cnt0;
  assign o_cnt1  = cur_sel ? s_cnt1  : w_cnt1;
  assign o_ovf   = cur_sel ? s_ovf   : w_ovf;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] mode;
    logic [1:0] exp_ready;
    logic [1:0] exp_done;
    logic       exp_ovf;
    logic [3:0] exp_cnt0;
    logic [3:0] exp_cnt1;
  } vec_t;

  vec_t       vecs [9];
  logic [1:0] exp_rr [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the selected DUT in IDLE; returns at the negedge
  // right after write-back, so consecutive calls run at peak throughput.
  task automatic do_op(input logic sel, input logic [1:0] valid, input logic [1:0] mode,
                       input logic [1:0] exp_ready, input logic [1:0] exp_done,
                       input logic exp_ovf, input logic [3:0] e0, input logic [3:0] e1,
                       input string tag);
    cur_sel = sel;
    if (sel) begin s_valid = valid; s_mode = mode; end
    else     begin w_valid = valid; w_mode = mode; end
    #1 check({tag, " ready"}, o_ready, exp_ready);
    @(posedge clk);
    @(negedge clk);
    w_valid = 2'b00;
    s_valid = 2'b00;
    #1 check({tag, " ready in EXEC"}, o_ready, 2'b00);
    check({tag, " done in EXEC"}, o_done, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check({tag, " done"}, o_done, exp_done);
    check({tag, " ovf"},  o_ovf,  exp_ovf);
    check({tag, " cnt0"}, o_cnt0, e0);
    check({tag, " cnt1"}, o_cnt1, e1);
  endtask

  initial begin
    vecs[0] = '{2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 4'd1, 4'd0};
    vecs[1] = '{2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 4'd2, 4'd0};
    vecs[2] = '{2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 4'd3, 4'd0};
    vecs[3] = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 4'd3, 4'd15};
    vecs[4] = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 4'd3, 4'd0};
    vecs[5] = '{2'b11, 2'b00, 2'b01, 2'b01, 1'b0, 4'd4, 4'd0};
    vecs[6] = '{2'b11, 2'b11, 2'b10, 2'b10, 1'b1, 4'd4, 4'd15};
    vecs[7] = '{2'b11, 2'b01, 2'b01, 2'b01, 1'b0, 4'd3, 4'd15};
    vecs[8] = '{2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 4'd2, 4'd15};
    exp_rr = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    clr = 1'b0; cur_sel = 1'b0;
    w_valid = 2'b11; w_mode = 2'b00;
    s_valid = 2'b00; s_mode = 2'b00;

    // Reset state, with a request pending that must not be accepted.
    repeat (2) @(negedge clk);
    check("reset ready", w_ready, 2'b00);
    check("reset cnt0", w_cnt0, 4'd0);
    check("reset cnt1", w_cnt1, 4'd0);
    check("reset done", w_done, 2'b00);
    check("reset ovf",  w_ovf,  1'b0);
    w_valid = 2'b00;
    rst_n = 1'b1;

    // Table: single requester, wrap-around, and round-robin contention.
    for (int i = 0; i < 9; i++)
      do_op(1'b0, vecs[i].valid, vecs[i].mode, vecs[i].exp_ready, vecs[i].exp_done,
            vecs[i].exp_ovf, vecs[i].exp_cnt0, vecs[i].exp_cnt1, $sformatf("vec%0d", i));

    // Both requesters valid continuously from reset: grants alternate.
    rst_n = 1'b0;
    w_valid = 2'b11; w_mode = 2'b00;
    #1 check("rr reset ready", w_ready, 2'b00);
    check("rr async cnt0", w_cnt0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("rr cycle%0d ready", i), w_ready, exp_rr[i]);
      @(posedge clk);
      @(negedge clk);
    end
    check("rr cnt0", w_cnt0, 4'd2);
    check("rr cnt1", w_cnt1, 4'd2);

    // clr during EXEC: counters zeroed, no done, IDLE next, rr kept.
    w_valid = 2'b01;
    #1 check("clr accept ready", w_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    w_valid = 2'b00;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1 check("clr done", w_done, 2'b00);
    check("clr cnt0", w_cnt0, 4'd0);
    check("clr cnt1", w_cnt1, 4'd0);
    w_valid = 2'b11;
    #1 check("clr idle rr kept", w_ready, 2'b10);
    clr = 1'b1;
    #1 check("clr blocks ready", w_ready, 2'b00);
    w_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;

    // Reset mid-EXEC with cnt0=5.
    for (int i = 0; i < 5; i++)
      do_op(1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 4'(i + 1), 4'd0, $sformatf("pre%0d", i));
    w_valid = 2'b01;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid-exec async cnt0", w_cnt0, 4'd0);
    check("mid-exec ready in reset", w_ready, 2'b00);
    @(negedge clk);
    w_valid = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-reset done%0d", i), w_done, 2'b00);
    end
    w_valid = 2'b11;
    #1 check("post-reset rr", w_ready, 2'b01);
    w_valid = 2'b00;
    @(negedge clk);

    // Saturating instance: clamp at 0 and at 15.
    do_op(1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 4'd0, 4'd0, "sat dec0 at 0");
    for (int i = 0; i < 15; i++)
      do_op(1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 4'(i + 1), 4'd0, $sformatf("sat inc%0d", i));
    do_op(1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1, 4'd15, 4'd0, "sat inc0 at 15");
    do_op(1'b1, 2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 4'd15, 4'd0, "sat dec1 at 0");
    do_op(1'b1, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 4'd15, 4'd1, "sat inc1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/incdec_scheduler.md
INCDEC_SCHEDULER -- requirements
Module: incdec_scheduler

Interface
REQ-001 Parameters SHALL be: N, default 4, counter/operand width; SAT, default 0, 0 = wrap-around and 1 = saturate at 0 and 2^N-1.
REQ-002 Port clk SHALL be: input, 1 bit, single clock, all state on rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port clr SHALL be: input, 1 bit, synchronous clear of both counters.
REQ-005 Port req_valid SHALL be: input, 2 bits, per-requester operation request.
REQ-006 Port req_mode SHALL be: input, 2 bits, per-requester mode, 0 = increment and 1 = decrement.
REQ-007 Port req_ready SHALL be: output, 2 bits, per-requester accept, one-hot or zero.
REQ-008 Port cnt0 SHALL be: output, N bits, counter owned by requester 0.
REQ-009 Port cnt1 SHALL be: output, N bits, counter owned by requester 1.
REQ-010 Port done SHALL be: output, 2 bits, one-cycle pulse marking write-back for the requester.
REQ-011 Port ovf SHALL be: output, 1 bit, valid with done; set when the op wrapped (SAT=0) or was clamped (SAT=1).

Function
REQ-012 A single shared inc/dec datapath SHALL serve both counters; at most one operation is in flight.
REQ-013 The FSM SHALL have states IDLE and EXEC.
REQ-014 IDLE transition: if any req_valid is set, take grant g; set req_ready[g]=1 combinationally; latch g, req_mode[g] and the selected counter; go to EXEC.
REQ-015 A handshake SHALL occur only when req_valid[g] and req_ready[g] are both 1 in IDLE.
REQ-016 Requesters SHALL hold req_valid and req_mode stable until accepted.
REQ-017 EXEC SHALL last exactly one cycle; at its end, the result SHALL be written to cnt[g] and done[g] SHALL pulse with ovf; then the FSM returns to IDLE.
REQ-018 req_ready SHALL be 0 in EXEC.
REQ-019 Latency from accept edge to counter update SHALL be 1 cycle; peak throughput is 1 op per 2 cycles.
REQ-020 Arbitration SHALL be round-robin: pointer rr selects preferred requester; after a grant to g, rr becomes ~g; a lone requester is always granted.
REQ-021 Increment SHALL compute cnt+1 mod 2^N; decrement SHALL compute cnt-1 mod 2^N.
REQ-022 Overflow SHALL be flagged for increment from 2^N-1 and for decrement from 0.
REQ-023 When SAT=1 and the op overflows, the counter SHALL be unchanged, but done and ovf SHALL still pulse.
REQ-024 ovf SHALL be 0 whenever done is 0.
REQ-025 clr=1 SHALL zero both counters at the next edge, force IDLE, and suppress done for any op in EXEC.
REQ-026 During clr, req_ready SHALL be 0 and rr SHALL be unchanged.
REQ-027 The counter not granted SHALL never change except by clr or reset.

Reset
REQ-028 rst_n low SHALL asynchronously set cnt0=cnt1=0, state=IDLE, rr=0, done=0, ovf=0 and latched grant/mode=0.
REQ-029 Reset asserted mid-EXEC SHALL discard the operation, with no done pulse after release.
REQ-030 req_ready SHALL be 0 while rst_n is low.
REQ-031 Deassertion SHALL be synchronised externally; the first accept may occur on the first edge after release.

Structure
REQ-032 A shared package SHALL hold the state encoding constants (IDLE=0, EXEC=1) and the mode constants (MODE_INC=0, MODE_DEC=1).
REQ-033 The arithmetic SHALL be one instance of the existing ripple increment/decrement sub-module inc_dec with parameter N, input muxed from the granted counter.
REQ-034 Overflow SHALL be derived as operand all-ones for increment and all-zeros for decrement, outside inc_dec.
REQ-035 Saturation muxing, the arbiter and the FSM SHALL reside in incdec_scheduler; no other sub-modules.

Verification
REQ-036 Scenario (N=4, SAT=0): req_valid=01 and mode 0, 3 times -> cnt0=3; done[0] pulses 3 times, 2 cycles apart; cnt1=0; ovf=0.
REQ-037 Scenario: both requesters valid continuously from reset -> grants alternate 0,1,0,1; after 8 cycles, cnt0=2 and cnt1=2.
REQ-038 Scenario (SAT=0): cnt1=0, decrement -> cnt1=15 and ovf=1 with done[1]; then increment from 15 -> cnt1=0 and ovf=1.
REQ-039 Scenario (SAT=1): cnt0=15, increment -> cnt0 stays 15 with done[0]=1 and ovf=1; decrement at 0 -> stays 0 with ovf=1.
REQ-040 Scenario: accept an op, then assert clr during EXEC -> both counters 0, no done pulse, FSM in IDLE next cycle.
REQ-041 Scenario: rst_n pulsed low mid-EXEC with cnt0=5 -> cnt0=0 immediately (asynchronous), no done after release, rr=0.
